// File: rtl/input_ctrl_pkg.sv
// Shared types and default parameters for the input_ctrl block.
// Optional build macro used by this slice: INPUT_CTRL_OVERRUN_EN.
package input_ctrl_pkg;

   localparam int DEBOUNCE_DEFAULT = 500_000;
   localparam int SW_WIDTH_DEFAULT = 4;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } state_t;

endpackage

// File: rtl/input_ctrl_if.sv
// Handshake bundle between input_ctrl (master) and its consumer (slave).
interface input_ctrl_if
   import input_ctrl_pkg::*;
#(
   parameter int DATA_WIDTH = SW_WIDTH_DEFAULT
);

   logic [DATA_WIDTH-1:0] data;
   logic                  valid;
   logic                  pressed;
   logic                  overrun;
   logic                  ack;

   modport master (output data, output valid, output pressed, output overrun, input ack);
   modport slave  (input data, input valid, input pressed, input overrun, output ack);

endinterface

// File: rtl/input_ctrl_debounce.sv
// Two-flop synchroniser and counter debouncer for the push-button.
// rise pulses in the cycle before pressed goes 0->1, so users update alongside it.
module debounce
   import input_ctrl_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn,
   output logic pressed,
   output logic rise
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             btn_meta_reg;
   logic             btn_sync_reg;
   logic [CNT_W-1:0] cnt_reg;
   logic [CNT_W-1:0] cnt_next;
   logic             pressed_reg;
   logic             pressed_next;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         btn_meta_reg <= 1'b0;
         btn_sync_reg <= 1'b0;
         cnt_reg      <= '0;
         pressed_reg  <= 1'b0;
      end else begin
         btn_meta_reg <= btn;
         btn_sync_reg <= btn_meta_reg;
         cnt_reg      <= cnt_next;
         pressed_reg  <= pressed_next;
      end
   end

   always_comb begin
      cnt_next     = '0;
      pressed_next = pressed_reg;
      if (btn_sync_reg != pressed_reg) begin
         // Counter clears on the flip, so the next disagreement restarts from zero.
         if (cnt_reg == CNT_LAST) pressed_next = ~pressed_reg;
         else                     cnt_next     = cnt_reg + 1'b1;
      end
   end

   assign pressed = pressed_reg;
   assign rise    = pressed_next & ~pressed_reg;

endmodule

// File: rtl/input_ctrl.sv
// Debounced button + switch capture presented as a valid/ack input word.
// Define INPUT_CTRL_OVERRUN_EN to build the sticky dropped-press flag.
module input_ctrl
   import input_ctrl_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
   parameter int DATA_WIDTH      = SW_WIDTH_DEFAULT
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  btn,
   input  logic [DATA_WIDTH-1:0] sw,
   input_ctrl_if.master          bus
);

   logic [DATA_WIDTH-1:0] sw_meta_reg;
   logic [DATA_WIDTH-1:0] sw_sync_reg;
   logic                  press_evt;
   logic                  pressed;
   state_t                state_reg;
   state_t                state_next;
   logic [DATA_WIDTH-1:0] data_reg;
   logic [DATA_WIDTH-1:0] data_next;

   genvar gi;
   generate
      for (gi = 0; gi < DATA_WIDTH; gi++) begin : g_sw_sync
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               sw_meta_reg[gi] <= 1'b0;
               sw_sync_reg[gi] <= 1'b0;
            end else begin
               sw_meta_reg[gi] <= sw[gi];
               sw_sync_reg[gi] <= sw_meta_reg[gi];
            end
         end
      end
   endgenerate

   debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_debounce (
      .clk     (clk),
      .rst_n   (rst_n),
      .btn     (btn),
      .pressed (pressed),
      .rise    (press_evt)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= ST_EMPTY;
         data_reg  <= '0;
      end else begin
         state_reg <= state_next;
         data_reg  <= data_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      data_next  = data_reg;
      case (state_reg)
         ST_EMPTY: begin
            if (press_evt) begin
               data_next  = sw_sync_reg;
               state_next = ST_FULL;
            end
         end
         ST_FULL: begin
            // A press landing with the ack replaces the consumed word in place.
            if (press_evt && bus.ack) data_next  = sw_sync_reg;
            else if (bus.ack)         state_next = ST_EMPTY;
         end
         default: state_next = ST_EMPTY;
      endcase
   end

`ifdef INPUT_CTRL_OVERRUN_EN
   logic overrun_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         overrun_reg <= 1'b0;
      else if (state_reg == ST_FULL && press_evt && !bus.ack)
         overrun_reg <= 1'b1;
   end

   assign bus.overrun = overrun_reg;
`else
   assign bus.overrun = 1'b0;
`endif

   assign bus.data    = data_reg;
   assign bus.valid   = (state_reg == ST_FULL);
   assign bus.pressed = pressed;

endmodule

// File: tb/tb_input_ctrl.sv
// Directed bench for input_ctrl with DEBOUNCE_CYCLES=4, DATA_WIDTH=4.
module tb_input_ctrl;

`ifdef INPUT_CTRL_OVERRUN_EN
   localparam bit OVR_EXP = 1'b1;
`else
   localparam bit OVR_EXP = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n;
   logic       btn;
   logic [3:0] sw;
   int         chk_cnt  = 0;
   int         pass_cnt = 0;

   input_ctrl_if #(.DATA_WIDTH(4)) bus ();

   input_ctrl #(
      .DEBOUNCE_CYCLES (4),
      .DATA_WIDTH      (4)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .btn   (btn),
      .sw    (sw),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n    = 1'b0;
      btn      = 1'b0;
      sw       = 4'h0;
      bus.ack  = 1'b0;
      repeat (3) begin
         tick();
         chk_cnt++;
         if ({bus.data, bus.valid, bus.pressed, bus.overrun} !== 7'b0)
            $display("FAIL reset_hold: got %b expected %b", {bus.data, bus.valid, bus.pressed, bus.overrun}, 7'b0);
         else pass_cnt++;
      end
      rst_n = 1'b1;
      repeat (8) begin
         tick();
         chk_cnt++;
         if ({bus.data, bus.valid, bus.pressed, bus.overrun} !== 7'b0)
            $display("FAIL reset_idle: got %b expected %b", {bus.data, bus.valid, bus.pressed, bus.overrun}, 7'b0);
         else pass_cnt++;
      end
      $display("txn reset: held 3 cycles, idle 8 cycles");
   endtask

   task automatic test_press_ack();
      logic [5:0] exp;
      sw = 4'hA;
      repeat (3) tick();
      btn = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         tick();
         exp = (k == 6) ? {1'b1, 1'b1, 4'hA} : 6'b0;
         chk_cnt++;
         if ({bus.pressed, bus.valid, bus.data} !== exp)
            $display("FAIL press_latency_k%0d: got %b expected %b", k, {bus.pressed, bus.valid, bus.data}, exp);
         else pass_cnt++;
      end
      bus.ack = 1'b1;
      tick();
      bus.ack = 1'b0;
      chk_cnt++;
      if ({bus.valid, bus.data} !== {1'b0, 4'hA})
         $display("FAIL ack_clear: got %b expected %b", {bus.valid, bus.data}, {1'b0, 4'hA});
      else pass_cnt++;
      btn = 1'b0;
      repeat (8) tick();
      chk_cnt++;
      if ({bus.pressed, bus.valid} !== 2'b00)
         $display("FAIL release: got %b expected %b", {bus.pressed, bus.valid}, 2'b00);
      else pass_cnt++;
      $display("txn press_ack: sw=A captured, ack consumed, released");
   endtask

   task automatic test_glitch();
      for (int r = 0; r < 10; r++) begin
         for (int c = 0; c < 6; c++) begin
            btn = (c < 3);
            tick();
            chk_cnt++;
            if ({bus.pressed, bus.valid} !== 2'b00)
               $display("FAIL glitch_r%0d_c%0d: got %b expected %b", r, c, {bus.pressed, bus.valid}, 2'b00);
            else pass_cnt++;
         end
      end
      btn = 1'b0;
      repeat (6) tick();
      $display("txn glitch: 10 pulses of 3 high / 3 low");
   endtask

   task automatic test_overrun();
      sw = 4'hA;
      repeat (3) tick();
      btn = 1'b1;
      repeat (6) tick();
      chk_cnt++;
      if ({bus.pressed, bus.valid, bus.data} !== {1'b1, 1'b1, 4'hA})
         $display("FAIL ovr_fill: got %b expected %b", {bus.pressed, bus.valid, bus.data}, {1'b1, 1'b1, 4'hA});
      else pass_cnt++;
      btn = 1'b0;
      repeat (8) tick();
      sw = 4'h5;
      repeat (3) tick();
      btn = 1'b1;
      repeat (5) tick();
      chk_cnt++;
      if ({bus.pressed, bus.overrun} !== 2'b00)
         $display("FAIL ovr_pre: got %b expected %b", {bus.pressed, bus.overrun}, 2'b00);
      else pass_cnt++;
      tick();
      chk_cnt++;
      if ({bus.pressed, bus.valid, bus.data, bus.overrun} !== {1'b1, 1'b1, 4'hA, OVR_EXP})
         $display("FAIL ovr_drop: got %b expected %b", {bus.pressed, bus.valid, bus.data, bus.overrun},
                  {1'b1, 1'b1, 4'hA, OVR_EXP});
      else pass_cnt++;
      btn = 1'b0;
      repeat (8) tick();
      chk_cnt++;
      if ({bus.valid, bus.data, bus.overrun} !== {1'b1, 4'hA, OVR_EXP})
         $display("FAIL ovr_hold: got %b expected %b", {bus.valid, bus.data, bus.overrun}, {1'b1, 4'hA, OVR_EXP});
      else pass_cnt++;
      $display("txn overrun: second press while full with sw=5");
   endtask

   task automatic test_ack_collide();
      sw = 4'h3;
      repeat (3) tick();
      btn = 1'b1;
      repeat (5) tick();
      bus.ack = 1'b1;
      tick();
      bus.ack = 1'b0;
      chk_cnt++;
      if ({bus.pressed, bus.valid, bus.data, bus.overrun} !== {1'b1, 1'b1, 4'h3, OVR_EXP})
         $display("FAIL collide_reload: got %b expected %b", {bus.pressed, bus.valid, bus.data, bus.overrun},
                  {1'b1, 1'b1, 4'h3, OVR_EXP});
      else pass_cnt++;
      tick();
      chk_cnt++;
      if ({bus.valid, bus.data} !== {1'b1, 4'h3})
         $display("FAIL collide_hold: got %b expected %b", {bus.valid, bus.data}, {1'b1, 4'h3});
      else pass_cnt++;
      bus.ack = 1'b1;
      tick();
      bus.ack = 1'b0;
      chk_cnt++;
      if ({bus.valid, bus.data, bus.overrun} !== {1'b0, 4'h3, OVR_EXP})
         $display("FAIL collide_consume: got %b expected %b", {bus.valid, bus.data, bus.overrun}, {1'b0, 4'h3, OVR_EXP});
      else pass_cnt++;
      btn = 1'b0;
      repeat (8) tick();
      $display("txn ack_collide: press with ack reloads sw=3");
   endtask

   task automatic test_reset_mid();
      logic [5:0] exp;
      btn = 1'b1;
      repeat (2) tick();
      rst_n = 1'b0;
      #1;
      chk_cnt++;
      if ({bus.data, bus.valid, bus.pressed, bus.overrun} !== 7'b0)
         $display("FAIL rstmid_async: got %b expected %b", {bus.data, bus.valid, bus.pressed, bus.overrun}, 7'b0);
      else pass_cnt++;
      repeat (2) tick();
      chk_cnt++;
      if ({bus.data, bus.valid, bus.pressed, bus.overrun} !== 7'b0)
         $display("FAIL rstmid_hold: got %b expected %b", {bus.data, bus.valid, bus.pressed, bus.overrun}, 7'b0);
      else pass_cnt++;
      rst_n = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         tick();
         exp = (k == 6) ? {1'b1, 1'b1, 4'h3} : 6'b0;
         chk_cnt++;
         if ({bus.pressed, bus.valid, bus.data} !== exp || bus.overrun !== 1'b0)
            $display("FAIL rstmid_k%0d: got %b ovr %b expected %b ovr 0", k, {bus.pressed, bus.valid, bus.data},
                     bus.overrun, exp);
         else pass_cnt++;
      end
      btn = 1'b0;
      $display("txn reset_mid: reset during debounce, press after release");
   endtask

   initial begin
      test_reset();
      test_press_ack();
      test_glitch();
      test_overrun();
      test_ack_collide();
      test_reset_mid();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
